md_sequencer: RTL and testbench
===============================

# md_sequencer

Sequencer that owns the HI/LO register pair and shares the multiplier and divider units between the MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO instructions of the 5-stage CPU. It sits beside the execute stage. It accepts one multiply/divide request per cycle from decode, drives the `mul`/`div` enables and operands as a registered one-cycle pulse, and waits for the matching completion. It then commits the result to HI/LO and tells the data-hazard unit when decode must stall.

## Interface
- `WATCHDOG`, default 64: maximum number of WAIT cycles before an issued operation is abandoned.
- `clk` in 1: single clock. All state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `de_md_valid` in 1: decode presents an MD op this cycle.
- `de_md_op` in 3: op code. 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Codes 110 and 111 are ignored.
- `de_md_src1`, `de_md_src2` in 32 each: rs and rt values. MTHI/MTLO use src1 only.
- `de_mf_req` in 1: MFHI/MFLO in decode.
- `de_mf_sel` in 1: selects the read source. 0 = LO, 1 = HI.
- `exe_cancel` in 1: exception in execute this cycle. Blocks acceptance.
- `md_stall` out 1: stall request to the hazard unit.
- `mul_en`, `div_en` out 1 each: one-cycle issue pulses to the units.
- `md_signed` out 1: signed-operation flag.
- `md_x`, `md_y` out 32 each: unit operands.
- `mul_complete`, `div_complete` in 1 each: unit completion pulses.
- `mul_result` in 64: multiplier result.
- `div_result` in 64: divider result, packed as {remainder, quotient}.
- `hi`, `lo` out 32 each: architectural HI and LO.
- `mf_data` out 32: MFHI/MFLO read data.
- `md_timeout` out 1: sticky watchdog flag.

## Operation
- States:
  - IDLE: nothing in flight.
  - ISSUE: enable pulse being driven.
  - WAIT: waiting for completion.
- Accept condition: `acc = de_md_valid & ~exe_cancel & ~md_stall & (de_md_op <= 3'b101)`.
- MTHI/MTLO on `acc`: write `hi` or `lo` from `de_md_src1` at the same edge. State does not change.
- MULT/MULTU/DIV/DIVU on `acc`:
  - Latch src1, src2, the kind (mul or div) and the signed flag (op[0]==0) into `md_x`, `md_y` and `md_signed`.
  - Go to ISSUE.
- DIV/DIVU with `de_md_src2 == 0`: accepted but not issued. HI/LO stay unchanged and state stays IDLE.
- ISSUE (exactly 1 cycle):
  - `mul_en` or `div_en` is high, according to the latched kind.
  - Clear the WAIT counter, then go to WAIT.
- WAIT:
  - Only the matching unit's completion pulse is honoured. The other unit's pulse is ignored.
  - On the matching complete: mul writes {hi, lo} <= `mul_result`; div writes hi <= `div_result[63:32]`, lo <= `div_result[31:0]`. Go to IDLE.
  - Otherwise the counter increments. When the counter reaches `WATCHDOG-1` without a complete: set `md_timeout`, go to IDLE, HI/LO unchanged.
- Back-to-back operation:
  - Stall: `md_stall = (de_md_valid | de_mf_req) & (state==ISSUE | (state==WAIT & ~matching_complete))`.
  - On the complete cycle, a new op in decode is accepted. MTHI/MTLO then takes priority over the completing write for its own register.
- Read path:
  - `mf_data` selects `hi` or `lo` per `de_mf_sel`.
  - On the completion cycle, `mf_data` bypasses the completing result instead of the register.
- `exe_cancel` affects acceptance only. An operation already in ISSUE or WAIT always completes.

## Timing
- Reset (synchronous, `resetn`==0 at an edge):
  - State = IDLE.
  - `hi`, `lo`, `md_x`, `md_y`, counter = 0.
  - `mul_en`, `div_en`, `md_signed`, `md_timeout` = 0.
  - This applies even mid-ISSUE or mid-WAIT. A late completion after reset is ignored because state is IDLE.
- Issue latency: accept at edge N → enable high during cycle N+1 → WAIT from N+2.
- Commit: HI/LO update at the edge that ends the complete cycle. Visible on `hi`/`lo` the following cycle, and via bypass during the complete cycle itself.
- MTHI/MTLO: zero stall. Visible on the next cycle.
- Enables are never high for two consecutive cycles. `mul_en` and `div_en` are never high together.

## Test plan
- MULT, src1=0xFFFFFFFE, src2=3; unit completes 2 cycles after `mul_en` → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA; `md_stall` high only for MFHI in ISSUE/WAIT.
- DIVU, src1=100, src2=7, followed immediately by MFLO → MFLO stalls until `div_complete`; `mf_data`=14 by bypass; then `hi`=2, `lo`=14.
- DIV with src2=0 → no `div_en`; `hi`/`lo` unchanged; no stall.
- MULT accepted, then MTLO 0x1234 presented on the complete cycle → `hi` from the product; `lo`=0x1234.
- DIV issued and `div_complete` never arrives → after 64 WAIT cycles `md_timeout`=1, state IDLE; a stray `mul_complete` during WAIT is ignored.
- `resetn` low during WAIT, then a late `mul_complete` → `hi`=`lo`=0, no commit; `exe_cancel` with MULT → not accepted, no `mul_en`.

Source files
------------

// File: rtl/md_sequencer.sv
// HI/LO owner and multiply/divide issue sequencer for the 5-stage CPU.
// Accepts MD ops from decode, pulses the shared units, commits results and drives decode stalls.
module md_sequencer #(
  parameter int WATCHDOG = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        de_md_valid,
  input  logic [2:0]  de_md_op,
  input  logic [31:0] de_md_src1,
  input  logic [31:0] de_md_src2,
  input  logic        de_mf_req,
  input  logic        de_mf_sel,
  input  logic        exe_cancel,
  output logic        md_stall,
  output logic        mul_en,
  output logic        div_en,
  output logic        md_signed,
  output logic [31:0] md_x,
  output logic [31:0] md_y,
  input  logic        mul_complete,
  input  logic        div_complete,
  input  logic [63:0] mul_result,
  input  logic [63:0] div_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data,
  output logic        md_timeout
);

  localparam int CW = $clog2(WATCHDOG + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          kind_div;
  logic          match_complete;
  logic [63:0]   done_result;
  logic          acc;
  logic          div_zero;
  logic          start;
  logic          timeout_hit;

  // Both units pack their result as {hi, lo}, so one mux feeds commit and bypass.
  assign match_complete = (state == WAIT) & (kind_div ? div_complete : mul_complete);
  assign done_result    = kind_div ? div_result : mul_result;
  assign timeout_hit    = (state == WAIT) & ~match_complete & (wait_cnt == CW'(WATCHDOG - 1));

  assign acc      = de_md_valid & ~exe_cancel & ~md_stall & (de_md_op <= 3'b101);
  assign div_zero = de_md_op[1] & (de_md_src2 == 32'd0);
  assign start    = acc & ~de_md_op[2] & ~div_zero;

  assign mf_data = match_complete ? (de_mf_sel ? done_result[63:32] : done_result[31:0])
                                  : (de_mf_sel ? hi : lo);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    md_stall  = (de_md_valid | de_mf_req) &
                ((state == ISSUE) | ((state == WAIT) & ~match_complete));
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A new op in decode may be accepted on the very cycle the old one completes.
        if (match_complete)   state_nxt = start ? ISSUE : IDLE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mul_en     <= 1'b0;
      div_en     <= 1'b0;
      md_signed  <= 1'b0;
      md_x       <= 32'd0;
      md_y       <= 32'd0;
      kind_div   <= 1'b0;
      wait_cnt   <= '0;
      md_timeout <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else begin
      mul_en <= start & ~de_md_op[1];
      div_en <= start &  de_md_op[1];
      if (start) begin
        md_x      <= de_md_src1;
        md_y      <= de_md_src2;
        md_signed <= ~de_md_op[0];
        kind_div  <= de_md_op[1];
      end
      if (state == ISSUE)
        wait_cnt <= '0;
      else if ((state == WAIT) & ~match_complete)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit)
        md_timeout <= 1'b1;
      if (match_complete) begin
        hi <= done_result[63:32];
        lo <= done_result[31:0];
      end
      // MTHI/MTLO are written last so they override a same-cycle commit to their register.
      if (acc & (de_md_op == 3'b100)) hi <= de_md_src1;
      if (acc & (de_md_op == 3'b101)) lo <= de_md_src1;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed scenarios plus randomized traffic
// against a transaction-level model that also plays the multiplier/divider units.
module tb_md_sequencer;

  localparam int WATCHDOG = 64;

  logic        clk = 1'b0;
  logic        resetn;
  logic        de_md_valid;
  logic [2:0]  de_md_op;
  logic [31:0] de_md_src1, de_md_src2;
  logic        de_mf_req, de_mf_sel, exe_cancel;
  logic        md_stall, mul_en, div_en, md_signed;
  logic [31:0] md_x, md_y;
  logic        mul_complete, div_complete;
  logic [63:0] mul_result, div_result;
  logic [31:0] hi, lo, mf_data;
  logic        md_timeout;

  md_sequencer #(.WATCHDOG(WATCHDOG)) dut (
    .clk(clk), .resetn(resetn),
    .de_md_valid(de_md_valid), .de_md_op(de_md_op),
    .de_md_src1(de_md_src1), .de_md_src2(de_md_src2),
    .de_mf_req(de_mf_req), .de_mf_sel(de_mf_sel), .exe_cancel(exe_cancel),
    .md_stall(md_stall), .mul_en(mul_en), .div_en(div_en), .md_signed(md_signed),
    .md_x(md_x), .md_y(md_y),
    .mul_complete(mul_complete), .div_complete(div_complete),
    .mul_result(mul_result), .div_result(div_result),
    .hi(hi), .lo(lo), .mf_data(mf_data), .md_timeout(md_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Stimulus for the next cycle.
  logic        s_rstn = 1'b1, s_valid = 1'b0, s_mfreq = 1'b0, s_sel = 1'b0, s_cancel = 1'b0;
  logic [2:0]  s_op = 3'd0;
  logic [31:0] s1 = 32'd0, s2 = 32'd0;
  logic        s_stray = 1'b0;
  int          cfg_delay = 2;
  logic        cfg_hang = 1'b0;

  // Reference model: architectural HI/LO plus at most one outstanding transaction,
  // tracked by its age in cycles since acceptance.
  logic [31:0] m_hi = '0, m_lo = '0, m_x = '0, m_y = '0;
  logic        m_signed = 1'b0, m_timeout = 1'b0;
  logic        pend = 1'b0, pend_div = 1'b0, pend_hang = 1'b0;
  logic [63:0] pend_res = '0;
  int          age = 0, pend_delay = 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expectResult(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  task automatic setInputs(input logic v, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic mf, input logic sel, input logic cn);
    s_valid = v; s_op = op; s1 = a; s2 = b; s_mfreq = mf; s_sel = sel; s_cancel = cn;
  endtask

  task automatic applyStimulus(output logic accepted);
    logic        in_issue, in_wait, match, exp_stall, acc, start;
    logic [31:0] exp_mf;
    @(negedge clk);
    in_issue = pend && (age == 1);
    in_wait  = pend && (age >= 2);
    match    = in_wait && !pend_hang && (age == 1 + pend_delay);
    mul_complete = 1'b0;
    div_complete = 1'b0;
    mul_result   = {$urandom, $urandom};
    div_result   = {$urandom, $urandom};
    if (match) begin
      if (pend_div) begin div_complete = 1'b1; div_result = pend_res; end
      else          begin mul_complete = 1'b1; mul_result = pend_res; end
    end
    if (s_stray) begin
      if (!pend || pend_div)  mul_complete = 1'b1;
      if (!pend || !pend_div) div_complete = 1'b1;
    end
    resetn = s_rstn; de_md_valid = s_valid; de_md_op = s_op; de_md_src1 = s1; de_md_src2 = s2;
    de_mf_req = s_mfreq; de_mf_sel = s_sel; exe_cancel = s_cancel;
    #1;
    exp_stall = (s_valid | s_mfreq) && (in_issue || (in_wait && !match));
    exp_mf    = match ? (s_sel ? pend_res[63:32] : pend_res[31:0]) : (s_sel ? m_hi : m_lo);
    checkOutput("md_stall", md_stall, exp_stall);
    checkOutput("mf_data", mf_data, exp_mf);
    acc      = s_valid && !s_cancel && !exp_stall && (s_op <= 3'd5);
    start    = acc && (s_op <= 3'd3) && !(s_op[1] && s2 == 32'd0);
    accepted = acc && s_rstn;
    if (!s_rstn) begin
      m_hi = '0; m_lo = '0; m_x = '0; m_y = '0; m_signed = 1'b0; m_timeout = 1'b0;
      pend = 1'b0; age = 0;
    end else begin
      if (match) begin
        {m_hi, m_lo} = pend_res;
        pend = 1'b0;
      end else if (in_wait && (age - 2 == WATCHDOG - 1)) begin
        m_timeout = 1'b1;
        pend = 1'b0;
      end else if (pend) begin
        age++;
      end
      if (acc && s_op == 3'd4) m_hi = s1;
      if (acc && s_op == 3'd5) m_lo = s1;
      if (start) begin
        pend = 1'b1; age = 1; pend_div = s_op[1];
        pend_delay = cfg_delay; pend_hang = cfg_hang;
        pend_res = expectResult(s_op, s1, s2);
        m_x = s1; m_y = s2; m_signed = !s_op[0];
      end
    end
    @(posedge clk);
    #1;
    checkOutput("hi", hi, m_hi);
    checkOutput("lo", lo, m_lo);
    checkOutput("md_timeout", md_timeout, m_timeout);
    checkOutput("mul_en", mul_en, pend && age == 1 && !pend_div);
    checkOutput("div_en", div_en, pend && age == 1 && pend_div);
    checkOutput("md_x", md_x, m_x);
    checkOutput("md_y", md_y, m_y);
    checkOutput("md_signed", md_signed, m_signed);
  endtask

  task automatic idleCycles(input int n);
    logic a;
    setInputs(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(a);
  endtask

  initial begin
    logic a;
    logic got;
    resetn = 1'b0; de_md_valid = 1'b0; de_md_op = 3'd0; de_md_src1 = '0; de_md_src2 = '0;
    de_mf_req = 1'b0; de_mf_sel = 1'b0; exe_cancel = 1'b0;
    mul_complete = 1'b0; div_complete = 1'b0; mul_result = '0; div_result = '0;
    repeat (2) @(posedge clk);

    s_rstn = 1'b0;
    idleCycles(1);
    s_rstn = 1'b1;

    // MULT -2 * 3, unit answers 2 cycles after mul_en, MFHI asked meanwhile.
    cfg_delay = 2;
    setInputs(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(a);
    checkOutput("mult_accept", a, 1'b1);
    setInputs(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(a);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFFA);

    // DIVU 100/7 followed by MFLO.
    setInputs(1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(a);
    setInputs(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(a);
    checkOutput("divu_hi", hi, 32'd2);
    checkOutput("divu_lo", lo, 32'd14);

    // DIV by zero: accepted, nothing issued, HI/LO untouched.
    setInputs(1'b1, 3'd2, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(a);
    checkOutput("div0_accept", a, 1'b1);
    idleCycles(2);
    checkOutput("div0_hi", hi, 32'd2);
    checkOutput("div0_lo", lo, 32'd14);

    // MULT 7*9 with MTLO held in decode until it is taken on the complete cycle.
    cfg_delay = 3;
    setInputs(1'b1, 3'd1, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0);
    applyStimulus(a);
    setInputs(1'b1, 3'd5, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) applyStimulus(got);
    checkOutput("mtlo_bound", got, 1'b1);
    idleCycles(1);
    checkOutput("mtlo_hi", hi, 32'd0);
    checkOutput("mtlo_lo", lo, 32'h1234);

    // DIV that never completes, with stray mul_complete pulses during WAIT.
    cfg_hang = 1'b1;
    setInputs(1'b1, 3'd2, 32'd50, 32'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(a);
    s_stray = 1'b1;
    idleCycles(WATCHDOG + 4);
    s_stray = 1'b0;
    cfg_hang = 1'b0;
    checkOutput("wd_timeout", md_timeout, 1'b1);
    checkOutput("wd_lo", lo, 32'h1234);

    // Reset during WAIT, then a late completion.
    cfg_delay = 5;
    setInputs(1'b1, 3'd0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(a);
    idleCycles(3);
    s_rstn = 1'b0;
    idleCycles(1);
    s_rstn = 1'b1;
    s_stray = 1'b1;
    idleCycles(1);
    s_stray = 1'b0;
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);

    // exe_cancel blocks a MULT.
    setInputs(1'b1, 3'd0, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
    applyStimulus(a);
    checkOutput("cancel_accept", a, 1'b0);
    checkOutput("cancel_mul_en", mul_en, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      s_rstn   = ($urandom_range(0, 299) != 0);
      s_valid  = ($urandom_range(0, 2) != 0);
      s_op     = 3'($urandom_range(0, 7));
      s1       = $urandom;
      s2       = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      s_mfreq  = $urandom_range(0, 1);
      s_sel    = $urandom_range(0, 1);
      s_cancel = ($urandom_range(0, 9) == 0);
      s_stray  = ($urandom_range(0, 9) == 0);
      cfg_delay = $urandom_range(1, 6);
      cfg_hang  = ($urandom_range(0, 49) == 0);
      applyStimulus(a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
